algo_4r1w_rd_tracker: RTL and testbench

- Sits directly downstream of the 4-read/1-write algorithmic memory.
- Tracks every accepted read on each of the 4 read ports through a fixed-latency tag pipeline and pairs it with the returning rd_vld/rd_dout.
- Flags protocol mismatches and counts single/double ECC error events per port.
- Presents a tagged, aligned read-response stream to the consumer logic.

---
 rtl/algo_4r1w_rd_tracker.sv | 186 ++++++++++++++++++
 tb/tb_algo_4r1w_rd_tracker.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/algo_4r1w_rd_tracker.sv
// Read-response tracker for the 4R1W algorithmic memory: pairs each accepted read with its
// returning rd_vld/rd_dout, flags protocol mismatches and counts ECC events per port.
// Optional macro ALGO_4R1W_RD_TRACKER_PADR_EN adds out_padr_o / err_padr_o.
module algo_4r1w_rd_tracker #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned BITADDR    = 13,
  parameter int unsigned BITTAG     = 4,
  parameter int unsigned READ_DELAY = 2,
  parameter int unsigned BITPADR    = 20,
  parameter int unsigned BITCNT     = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   ready_i,
  input  logic [3:0]             read_i,
  input  logic [4*BITADDR-1:0]   rd_adr_i,
  input  logic [4*BITTAG-1:0]    rd_tag_i,
  input  logic [3:0]             rd_vld_i,
  input  logic [4*WIDTH-1:0]     rd_dout_i,
  input  logic [3:0]             rd_serr_i,
  input  logic [3:0]             rd_derr_i,
  input  logic [4*BITPADR-1:0]   rd_padr_i,
  input  logic                   cnt_clr_i,
  output logic [3:0]             out_vld_o,
  output logic [4*BITTAG-1:0]    out_tag_o,
  output logic [4*BITADDR-1:0]   out_adr_o,
  output logic [4*WIDTH-1:0]     out_dout_o,
  output logic [3:0]             out_err_o,
  output logic [3:0]             mis_err_o,
  output logic [4*BITCNT-1:0]    serr_cnt_o,
  output logic [4*BITCNT-1:0]    derr_cnt_o
`ifdef ALGO_4R1W_RD_TRACKER_PADR_EN
  ,
  output logic [4*BITPADR-1:0]   out_padr_o,
  output logic [4*BITPADR-1:0]   err_padr_o
`endif
);

  localparam int unsigned NP = 4;
  localparam logic [BITCNT-1:0] CNT_MAX = '1;

  logic [READ_DELAY-1:0][NP-1:0]         pv_q, pv_d;
  logic [READ_DELAY-1:0][NP*BITADDR-1:0] pa_q, pa_d;
  logic [READ_DELAY-1:0][NP*BITTAG-1:0]  pt_q, pt_d;

  logic [NP-1:0]         exp_vld;
  logic [NP*BITADDR-1:0] exp_adr;
  logic [NP*BITTAG-1:0]  exp_tag;
  logic [NP-1:0]         hit;

  logic [NP-1:0]         out_vld_q, out_vld_d;
  logic [NP*BITTAG-1:0]  out_tag_q, out_tag_d;
  logic [NP*BITADDR-1:0] out_adr_q, out_adr_d;
  logic [NP*WIDTH-1:0]   out_dout_q, out_dout_d;
  logic [NP-1:0]         out_err_q, out_err_d;
  logic [NP-1:0]         mis_err_q, mis_err_d;
  logic [NP*BITCNT-1:0]  serr_cnt_q, serr_cnt_d;
  logic [NP*BITCNT-1:0]  derr_cnt_q, derr_cnt_d;

`ifdef ALGO_4R1W_RD_TRACKER_PADR_EN
  logic [NP*BITPADR-1:0] out_padr_q, out_padr_d;
  logic [NP*BITPADR-1:0] err_padr_q, err_padr_d;
`else
  logic unused_padr;
  assign unused_padr = ^rd_padr_i;
`endif

  // Tag pipeline: stage 0 captures the accept, last stage lines up with rd_vld.
  always_comb begin : pipe_next
    pv_d = '0;
    pa_d = '0;
    pt_d = '0;
    pv_d[0] = read_i & {NP{ready_i}};
    pa_d[0] = rd_adr_i;
    pt_d[0] = rd_tag_i;
    for (int unsigned s = 1; s < READ_DELAY; s++) begin
      pv_d[s] = pv_q[s-1];
      pa_d[s] = pa_q[s-1];
      pt_d[s] = pt_q[s-1];
    end
  end

  assign exp_vld = pv_q[READ_DELAY-1];
  assign exp_adr = pa_q[READ_DELAY-1];
  assign exp_tag = pt_q[READ_DELAY-1];
  assign hit     = exp_vld & rd_vld_i;

  // Response stage, mismatch flags and saturating error counters.
  always_comb begin : resp_next
    out_vld_d  = hit;
    out_tag_d  = out_tag_q;
    out_adr_d  = out_adr_q;
    out_dout_d = out_dout_q;
    out_err_d  = out_err_q;
    mis_err_d  = mis_err_q | (rd_vld_i ^ exp_vld);
    serr_cnt_d = serr_cnt_q;
    derr_cnt_d = derr_cnt_q;
`ifdef ALGO_4R1W_RD_TRACKER_PADR_EN
    out_padr_d = out_padr_q;
    err_padr_d = err_padr_q;
`endif
    for (int unsigned i = 0; i < NP; i++) begin
      if (hit[i]) begin
        out_tag_d[i*BITTAG +: BITTAG]    = exp_tag[i*BITTAG +: BITTAG];
        out_adr_d[i*BITADDR +: BITADDR]  = exp_adr[i*BITADDR +: BITADDR];
        out_dout_d[i*WIDTH +: WIDTH]     = rd_dout_i[i*WIDTH +: WIDTH];
        out_err_d[i]                     = rd_serr_i[i] | rd_derr_i[i];
`ifdef ALGO_4R1W_RD_TRACKER_PADR_EN
        out_padr_d[i*BITPADR +: BITPADR] = rd_padr_i[i*BITPADR +: BITPADR];
`endif
      end
      if (rd_vld_i[i]) begin
        if (rd_derr_i[i]) begin
          if (derr_cnt_q[i*BITCNT +: BITCNT] != CNT_MAX)
            derr_cnt_d[i*BITCNT +: BITCNT] = derr_cnt_q[i*BITCNT +: BITCNT] + BITCNT'(1);
`ifdef ALGO_4R1W_RD_TRACKER_PADR_EN
          // A zero double-error count means this is the first derr since the last clear.
          if (derr_cnt_q[i*BITCNT +: BITCNT] == '0)
            err_padr_d[i*BITPADR +: BITPADR] = rd_padr_i[i*BITPADR +: BITPADR];
`endif
        end else if (rd_serr_i[i]) begin
          if (serr_cnt_q[i*BITCNT +: BITCNT] != CNT_MAX)
            serr_cnt_d[i*BITCNT +: BITCNT] = serr_cnt_q[i*BITCNT +: BITCNT] + BITCNT'(1);
        end
      end
    end
    if (cnt_clr_i) begin
      mis_err_d  = '0;
      serr_cnt_d = '0;
      derr_cnt_d = '0;
`ifdef ALGO_4R1W_RD_TRACKER_PADR_EN
      err_padr_d = '0;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin : regs
    if (!rst_ni) begin
      pv_q       <= '0;
      pa_q       <= '0;
      pt_q       <= '0;
      out_vld_q  <= '0;
      out_tag_q  <= '0;
      out_adr_q  <= '0;
      out_dout_q <= '0;
      out_err_q  <= '0;
      mis_err_q  <= '0;
      serr_cnt_q <= '0;
      derr_cnt_q <= '0;
`ifdef ALGO_4R1W_RD_TRACKER_PADR_EN
      out_padr_q <= '0;
      err_padr_q <= '0;
`endif
    end else begin
      pv_q       <= pv_d;
      pa_q       <= pa_d;
      pt_q       <= pt_d;
      out_vld_q  <= out_vld_d;
      out_tag_q  <= out_tag_d;
      out_adr_q  <= out_adr_d;
      out_dout_q <= out_dout_d;
      out_err_q  <= out_err_d;
      mis_err_q  <= mis_err_d;
      serr_cnt_q <= serr_cnt_d;
      derr_cnt_q <= derr_cnt_d;
`ifdef ALGO_4R1W_RD_TRACKER_PADR_EN
      out_padr_q <= out_padr_d;
      err_padr_q <= err_padr_d;
`endif
    end
  end

  assign out_vld_o  = out_vld_q;
  assign out_tag_o  = out_tag_q;
  assign out_adr_o  = out_adr_q;
  assign out_dout_o = out_dout_q;
  assign out_err_o  = out_err_q;
  assign mis_err_o  = mis_err_q;
  assign serr_cnt_o = serr_cnt_q;
  assign derr_cnt_o = derr_cnt_q;
`ifdef ALGO_4R1W_RD_TRACKER_PADR_EN
  assign out_padr_o = out_padr_q;
  assign err_padr_o = err_padr_q;
`endif

endmodule

// File: tb/tb_algo_4r1w_rd_tracker.sv
// Bench for algo_4r1w_rd_tracker: directed scenarios plus a randomized run scored against a
// queue-based model of outstanding reads (due cycle = accept cycle + READ_DELAY).
module tb_algo_4r1w_rd_tracker;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned BITADDR = 13;
  localparam int unsigned BITTAG  = 4;
  localparam int unsigned RD      = 2;
  localparam int unsigned BITPADR = 20;
  localparam int unsigned BITCNT  = 8;
  localparam int          CMAX    = (2 ** BITCNT) - 1;

  logic                 clk, rst_n, ready, cnt_clr;
  logic [3:0]           read, rd_vld, rd_serr, rd_derr;
  logic [4*BITADDR-1:0] rd_adr;
  logic [4*BITTAG-1:0]  rd_tag;
  logic [4*WIDTH-1:0]   rd_dout;
  logic [4*BITPADR-1:0] rd_padr;
  logic [3:0]           out_vld, out_err, mis_err;
  logic [4*BITTAG-1:0]  out_tag;
  logic [4*BITADDR-1:0] out_adr;
  logic [4*WIDTH-1:0]   out_dout;
  logic [4*BITCNT-1:0]  serr_cnt, derr_cnt;
`ifdef ALGO_4R1W_RD_TRACKER_PADR_EN
  logic [4*BITPADR-1:0] out_padr, err_padr;
`endif

  algo_4r1w_rd_tracker #(
    .WIDTH(WIDTH), .BITADDR(BITADDR), .BITTAG(BITTAG),
    .READ_DELAY(RD), .BITPADR(BITPADR), .BITCNT(BITCNT)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .ready_i(ready), .read_i(read),
    .rd_adr_i(rd_adr), .rd_tag_i(rd_tag), .rd_vld_i(rd_vld), .rd_dout_i(rd_dout),
    .rd_serr_i(rd_serr), .rd_derr_i(rd_derr), .rd_padr_i(rd_padr), .cnt_clr_i(cnt_clr),
    .out_vld_o(out_vld), .out_tag_o(out_tag), .out_adr_o(out_adr), .out_dout_o(out_dout),
    .out_err_o(out_err), .mis_err_o(mis_err), .serr_cnt_o(serr_cnt), .derr_cnt_o(derr_cnt)
`ifdef ALGO_4R1W_RD_TRACKER_PADR_EN
    , .out_padr_o(out_padr), .err_padr_o(err_padr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a queue of outstanding reads per port, each stamped with its due cycle.
  typedef struct {
    int                 due;
    logic [BITADDR-1:0] adr;
    logic [BITTAG-1:0]  tag;
  } ent_t;

  ent_t                 pq[4][$];
  int                   cyc;
  logic [3:0]           m_vld, m_err, m_mis;
  logic [4*BITTAG-1:0]  m_tag;
  logic [4*BITADDR-1:0] m_adr;
  logic [4*WIDTH-1:0]   m_dout;
  int                   m_scnt[4];
  int                   m_dcnt[4];
`ifdef ALGO_4R1W_RD_TRACKER_PADR_EN
  logic [4*BITPADR-1:0] m_opadr, m_epadr;
  bit                   m_dseen[4];
`endif

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      pq[i].delete();
      m_scnt[i] = 0;
      m_dcnt[i] = 0;
`ifdef ALGO_4R1W_RD_TRACKER_PADR_EN
      m_dseen[i] = 1'b0;
`endif
    end
    m_vld = '0; m_err = '0; m_mis = '0; m_tag = '0; m_adr = '0; m_dout = '0;
`ifdef ALGO_4R1W_RD_TRACKER_PADR_EN
    m_opadr = '0; m_epadr = '0;
`endif
  endtask

  task automatic model_step();
    bit   due;
    ent_t e;
    for (int i = 0; i < 4; i++) begin
      due = (pq[i].size() > 0) && (pq[i][0].due == cyc);
      if (due) e = pq[i].pop_front();
      m_vld[i] = due && rd_vld[i];
      if (m_vld[i]) begin
        m_tag[i*BITTAG +: BITTAG]   = e.tag;
        m_adr[i*BITADDR +: BITADDR] = e.adr;
        m_dout[i*WIDTH +: WIDTH]    = rd_dout[i*WIDTH +: WIDTH];
        m_err[i]                    = rd_serr[i] | rd_derr[i];
`ifdef ALGO_4R1W_RD_TRACKER_PADR_EN
        m_opadr[i*BITPADR +: BITPADR] = rd_padr[i*BITPADR +: BITPADR];
`endif
      end
      if (cnt_clr) begin
        m_mis[i] = 1'b0; m_scnt[i] = 0; m_dcnt[i] = 0;
`ifdef ALGO_4R1W_RD_TRACKER_PADR_EN
        m_dseen[i] = 1'b0; m_epadr[i*BITPADR +: BITPADR] = '0;
`endif
      end else begin
        if (due != rd_vld[i]) m_mis[i] = 1'b1;
        if (rd_vld[i] && rd_derr[i]) begin
          if (m_dcnt[i] < CMAX) m_dcnt[i]++;
`ifdef ALGO_4R1W_RD_TRACKER_PADR_EN
          if (!m_dseen[i]) begin
            m_dseen[i] = 1'b1;
            m_epadr[i*BITPADR +: BITPADR] = rd_padr[i*BITPADR +: BITPADR];
          end
`endif
        end else if (rd_vld[i] && rd_serr[i]) begin
          if (m_scnt[i] < CMAX) m_scnt[i]++;
        end
      end
      if (read[i] && ready)
        pq[i].push_back('{due: cyc + int'(RD), adr: rd_adr[i*BITADDR +: BITADDR],
                          tag: rd_tag[i*BITTAG +: BITTAG]});
    end
    cyc++;
  endtask

  // One clock: DUT and model both advance on the rising edge; return on the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    ready = 1'b1; read = '0; rd_vld = '0; rd_serr = '0; rd_derr = '0; cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) cycle();
    n_checks += 8;
    if (out_vld !== 4'h0) begin n_fail++; $display("FAIL reset out_vld got %h exp 0", out_vld); end
    if (out_tag !== '0) begin n_fail++; $display("FAIL reset out_tag got %h exp 0", out_tag); end
    if (out_adr !== '0) begin n_fail++; $display("FAIL reset out_adr got %h exp 0", out_adr); end
    if (out_dout !== '0) begin n_fail++; $display("FAIL reset out_dout got %h exp 0", out_dout); end
    if (out_err !== 4'h0) begin n_fail++; $display("FAIL reset out_err got %h exp 0", out_err); end
    if (mis_err !== 4'h0) begin n_fail++; $display("FAIL reset mis_err got %h exp 0", mis_err); end
    if (serr_cnt !== '0) begin n_fail++; $display("FAIL reset serr_cnt got %h exp 0", serr_cnt); end
    if (derr_cnt !== '0) begin n_fail++; $display("FAIL reset derr_cnt got %h exp 0", derr_cnt); end
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_single();
    logic [WIDTH-1:0] d;
    d = WIDTH'($urandom);
    idle();
    read[0] = 1'b1; rd_adr[BITADDR-1:0] = BITADDR'(13'h0123); rd_tag[BITTAG-1:0] = 4'd5;
    cycle();
    idle();
    cycle();
    n_checks++;
    if (out_vld !== 4'h0) begin n_fail++; $display("FAIL single early out_vld got %h exp 0", out_vld); end
    rd_vld[0] = 1'b1; rd_dout[WIDTH-1:0] = d;
    cycle();
    idle();
    n_checks += 5;
    if (out_vld !== 4'h1) begin n_fail++; $display("FAIL single out_vld got %h exp 1", out_vld); end
    if (out_adr[BITADDR-1:0] !== 13'h0123) begin n_fail++; $display("FAIL single out_adr got %h exp 0123", out_adr[BITADDR-1:0]); end
    if (out_tag[BITTAG-1:0] !== 4'd5) begin n_fail++; $display("FAIL single out_tag got %h exp 5", out_tag[BITTAG-1:0]); end
    if (out_dout[WIDTH-1:0] !== d) begin n_fail++; $display("FAIL single out_dout got %h exp %h", out_dout[WIDTH-1:0], d); end
    if (mis_err !== 4'h0) begin n_fail++; $display("FAIL single mis_err got %h exp 0", mis_err); end
    cycle();
  endtask

  task automatic test_all_ports();
    logic [4*BITADDR-1:0] a;
    for (int i = 0; i < 4; i++) begin
      a[i*BITADDR +: BITADDR] = BITADDR'($urandom);
      rd_tag[i*BITTAG +: BITTAG] = BITTAG'(i + 1);
    end
    idle();
    read = 4'hf; rd_adr = a;
    cycle();
    idle();
    cycle();
    rd_vld = 4'hf;
    cycle();
    idle();
    n_checks += 4;
    if (out_vld !== 4'hf) begin n_fail++; $display("FAIL all_ports out_vld got %h exp f", out_vld); end
    if (out_tag !== 16'h4321) begin n_fail++; $display("FAIL all_ports out_tag got %h exp 4321", out_tag); end
    if (out_adr !== a) begin n_fail++; $display("FAIL all_ports out_adr got %h exp %h", out_adr, a); end
    if (mis_err !== 4'h0) begin n_fail++; $display("FAIL all_ports mis_err got %h exp 0", mis_err); end
    cycle();
  endtask

  task automatic test_dropped();
    idle();
    ready = 1'b0; read[2] = 1'b1;
    cycle();
    idle();
    cycle();
    rd_vld[2] = 1'b1;
    cycle();
    idle();
    n_checks += 2;
    if (out_vld !== 4'h0) begin n_fail++; $display("FAIL dropped out_vld got %h exp 0", out_vld); end
    if (mis_err !== 4'h4) begin n_fail++; $display("FAIL dropped mis_err got %h exp 4", mis_err); end
    cycle();
    n_checks++;
    if (mis_err !== 4'h4) begin n_fail++; $display("FAIL dropped sticky mis_err got %h exp 4", mis_err); end
    cnt_clr = 1'b1;
    cycle();
    idle();
    n_checks++;
    if (mis_err !== 4'h0) begin n_fail++; $display("FAIL dropped clr mis_err got %h exp 0", mis_err); end
  endtask

  task automatic test_err_count();
    idle();
    rd_vld[1] = 1'b1; rd_serr[1] = 1'b1;
    cycle();
    rd_serr[1] = 1'b0; rd_derr[1] = 1'b1;
    cycle();
    rd_serr[1] = 1'b1;
    cycle();
    idle();
    n_checks += 3;
    if (serr_cnt[BITCNT +: BITCNT] !== 8'd1) begin n_fail++; $display("FAIL errcnt serr got %0d exp 1", serr_cnt[BITCNT +: BITCNT]); end
    if (derr_cnt[BITCNT +: BITCNT] !== 8'd2) begin n_fail++; $display("FAIL errcnt derr got %0d exp 2", derr_cnt[BITCNT +: BITCNT]); end
    if (mis_err !== 4'h2) begin n_fail++; $display("FAIL errcnt mis_err got %h exp 2", mis_err); end
    rd_vld[1] = 1'b1; rd_serr[1] = 1'b1;
    repeat (CMAX - 2) cycle();
    n_checks++;
    if (serr_cnt[BITCNT +: BITCNT] !== 8'hFE) begin n_fail++; $display("FAIL errcnt near_sat got %h exp fe", serr_cnt[BITCNT +: BITCNT]); end
    cycle();
    n_checks++;
    if (serr_cnt[BITCNT +: BITCNT] !== 8'hFF) begin n_fail++; $display("FAIL errcnt sat got %h exp ff", serr_cnt[BITCNT +: BITCNT]); end
    repeat (2) cycle();
    n_checks++;
    if (serr_cnt[BITCNT +: BITCNT] !== 8'hFF) begin n_fail++; $display("FAIL errcnt no_wrap got %h exp ff", serr_cnt[BITCNT +: BITCNT]); end
    idle();
    rd_vld[1] = 1'b1; rd_derr[1] = 1'b1; cnt_clr = 1'b1;
    cycle();
    idle();
    n_checks += 3;
    if (derr_cnt !== '0) begin n_fail++; $display("FAIL clr_wins derr_cnt got %h exp 0", derr_cnt); end
    if (serr_cnt !== '0) begin n_fail++; $display("FAIL clr_wins serr_cnt got %h exp 0", serr_cnt); end
    if (mis_err !== 4'h0) begin n_fail++; $display("FAIL clr_wins mis_err got %h exp 0", mis_err); end
  endtask

`ifdef ALGO_4R1W_RD_TRACKER_PADR_EN
  task automatic test_padr();
    idle();
    rd_vld[0] = 1'b1; rd_derr[0] = 1'b1; rd_padr[BITPADR-1:0] = 20'h1A5A5;
    cycle();
    rd_padr[BITPADR-1:0] = 20'h00001;
    cycle();
    idle();
    n_checks += 2;
    if (err_padr[BITPADR-1:0] !== 20'h1A5A5) begin n_fail++; $display("FAIL padr err_padr got %h exp 1a5a5", err_padr[BITPADR-1:0]); end
    if (derr_cnt[BITCNT-1:0] !== 8'd2) begin n_fail++; $display("FAIL padr derr_cnt got %0d exp 2", derr_cnt[BITCNT-1:0]); end
    cnt_clr = 1'b1;
    cycle();
    idle();
    n_checks++;
    if (err_padr !== '0) begin n_fail++; $display("FAIL padr clr err_padr got %h exp 0", err_padr); end
  endtask
`endif

  task automatic test_reset_midflight();
    idle();
    rd_vld[2] = 1'b1; rd_derr[2] = 1'b1;
    cycle();
    idle();
    read = 4'b1001;
    cycle();
    idle();
    n_checks++;
    if (mis_err !== 4'h4) begin n_fail++; $display("FAIL midrst pre mis_err got %h exp 4", mis_err); end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks += 4;
    if (out_vld !== 4'h0) begin n_fail++; $display("FAIL midrst out_vld got %h exp 0", out_vld); end
    if (mis_err !== 4'h0) begin n_fail++; $display("FAIL midrst mis_err got %h exp 0", mis_err); end
    if (derr_cnt !== '0) begin n_fail++; $display("FAIL midrst derr_cnt got %h exp 0", derr_cnt); end
    if (out_tag !== '0) begin n_fail++; $display("FAIL midrst out_tag got %h exp 0", out_tag); end
    @(negedge clk);
    rst_n = 1'b1;
    rd_vld = 4'b1001;
    cycle();
    idle();
    n_checks += 2;
    if (mis_err !== 4'b1001) begin n_fail++; $display("FAIL midrst late mis_err got %h exp 9", mis_err); end
    if (out_vld !== 4'h0) begin n_fail++; $display("FAIL midrst late out_vld got %h exp 0", out_vld); end
    cnt_clr = 1'b1;
    cycle();
    idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      ready   = ($urandom % 4) != 0;
      read    = 4'($urandom);
      cnt_clr = ($urandom % 64) == 0;
      for (int i = 0; i < 4; i++) begin
        bit due;
        due = (pq[i].size() > 0) && (pq[i][0].due == cyc);
        rd_vld[i]  = due ? (($urandom % 16) != 0) : (($urandom % 32) == 0);
        rd_serr[i] = ($urandom % 4) == 0;
        rd_derr[i] = ($urandom % 6) == 0;
        rd_adr[i*BITADDR +: BITADDR]  = BITADDR'($urandom);
        rd_tag[i*BITTAG +: BITTAG]    = BITTAG'($urandom);
        rd_dout[i*WIDTH +: WIDTH]     = WIDTH'($urandom);
        rd_padr[i*BITPADR +: BITPADR] = BITPADR'($urandom);
      end
      cycle();
      n_checks += 6;
      if (out_vld !== m_vld) begin n_fail++; $display("FAIL rand[%0d] out_vld got %h exp %h", c, out_vld, m_vld); end
      if (out_tag !== m_tag) begin n_fail++; $display("FAIL rand[%0d] out_tag got %h exp %h", c, out_tag, m_tag); end
      if (out_adr !== m_adr) begin n_fail++; $display("FAIL rand[%0d] out_adr got %h exp %h", c, out_adr, m_adr); end
      if (out_dout !== m_dout) begin n_fail++; $display("FAIL rand[%0d] out_dout got %h exp %h", c, out_dout, m_dout); end
      if (out_err !== m_err) begin n_fail++; $display("FAIL rand[%0d] out_err got %h exp %h", c, out_err, m_err); end
      if (mis_err !== m_mis) begin n_fail++; $display("FAIL rand[%0d] mis_err got %h exp %h", c, mis_err, m_mis); end
      for (int i = 0; i < 4; i++) begin
        n_checks += 2;
        if (serr_cnt[i*BITCNT +: BITCNT] !== BITCNT'(m_scnt[i])) begin
          n_fail++; $display("FAIL rand[%0d] serr_cnt[%0d] got %0d exp %0d", c, i, serr_cnt[i*BITCNT +: BITCNT], m_scnt[i]);
        end
        if (derr_cnt[i*BITCNT +: BITCNT] !== BITCNT'(m_dcnt[i])) begin
          n_fail++; $display("FAIL rand[%0d] derr_cnt[%0d] got %0d exp %0d", c, i, derr_cnt[i*BITCNT +: BITCNT], m_dcnt[i]);
        end
      end
`ifdef ALGO_4R1W_RD_TRACKER_PADR_EN
      n_checks += 2;
      if (out_padr !== m_opadr) begin n_fail++; $display("FAIL rand[%0d] out_padr got %h exp %h", c, out_padr, m_opadr); end
      if (err_padr !== m_epadr) begin n_fail++; $display("FAIL rand[%0d] err_padr got %h exp %h", c, err_padr, m_epadr); end
`endif
    end
    idle();
  endtask

  initial begin
    cyc = 0;
    rst_n = 1'b0;
    rd_adr = '0; rd_tag = '0; rd_dout = '0; rd_padr = '0;
    idle();
    @(negedge clk);
    test_reset();
    test_single();
    test_all_ports();
    test_dropped();
    test_err_count();
`ifdef ALGO_4R1W_RD_TRACKER_PADR_EN
    test_padr();
`endif
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
